// File: rtl/sqrt_controller.sv
// Sequencing controller for the max/min magnitude approximation datapath.
// Every output is a registered decode of the next state, so start never reaches an output combinationally.
module sqrt_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       WER1,
    output logic       RER1,
    output logic       WER2,
    output logic       RER2,
    output logic       WER3,
    output logic       RER3,
    output logic [2:0] WAR1,
    output logic [2:0] RAR1,
    output logic [2:0] WAR2,
    output logic [2:0] RAR2,
    output logic [2:0] WAR3,
    output logic [2:0] RAR3,
    output logic       WER4,
    output logic       RR4,
    output logic       WER5,
    output logic       RR5,
    output logic [1:0] AU1,
    output logic [1:0] AU2,
    output logic [9:0] trictrl,
    output logic       OE
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_ABSA   = 4'd2,
        S_ABSB   = 4'd3,
        S_MAXX   = 4'd4,
        S_MINSUB = 4'd5,
        S_ADD    = 4'd6,
        S_MAX2   = 4'd7,
        S_OUT    = 4'd8
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       oe;
        logic [9:0] trictrl;
        logic [1:0] au1;
        logic [1:0] au2;
        logic       wer1;
        logic       rer1;
        logic       wer2;
        logic       rer2;
        logic       wer3;
        logic       rer3;
        logic       wer4;
        logic       rr4;
        logic       wer5;
        logic       rr5;
        logic [2:0] war1;
        logic [2:0] rar1;
        logic [2:0] war2;
        logic [2:0] rar2;
        logic [2:0] war3;
        logic [2:0] rar3;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   state_d = S_ABSA;
            S_ABSA:   state_d = S_ABSB;
            S_ABSB:   state_d = S_MAXX;
            S_MAXX:   state_d = S_MINSUB;
            S_MINSUB: state_d = S_ADD;
            S_ADD:    state_d = S_MAX2;
            S_MAX2:   state_d = S_OUT;
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Decode the state being entered so the control word lines up with that state's cycle.
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.busy = (state_d != S_IDLE);
        unique case (state_d)
            S_LOAD: begin
                ctrl_d.trictrl[2] = 1'b1;
                ctrl_d.trictrl[4] = 1'b1;
                ctrl_d.wer1       = 1'b1;
                ctrl_d.war1       = 3'd0;
                ctrl_d.wer2       = 1'b1;
                ctrl_d.war2       = 3'd0;
            end
            S_ABSA: begin
                ctrl_d.rer1       = 1'b1;
                ctrl_d.rar1       = 3'd0;
                ctrl_d.au1        = 2'b00;
                ctrl_d.trictrl[3] = 1'b1;
                ctrl_d.wer1       = 1'b1;
                ctrl_d.war1       = 3'd1;
            end
            S_ABSB: begin
                ctrl_d.rer2       = 1'b1;
                ctrl_d.rar2       = 3'd0;
                ctrl_d.trictrl[1] = 1'b1;
                ctrl_d.au1        = 2'b11;
                ctrl_d.trictrl[5] = 1'b1;
                ctrl_d.wer2       = 1'b1;
                ctrl_d.war2       = 3'd1;
            end
            S_MAXX: begin
                ctrl_d.rer1       = 1'b1;
                ctrl_d.rar1       = 3'd1;
                ctrl_d.rer2       = 1'b1;
                ctrl_d.rar2       = 3'd1;
                ctrl_d.trictrl[1] = 1'b1;
                ctrl_d.au1        = 2'b10;
                ctrl_d.wer4       = 1'b1;
                ctrl_d.trictrl[6] = 1'b1;
                ctrl_d.wer3       = 1'b1;
                ctrl_d.war3       = 3'd0;
            end
            S_MINSUB: begin
                // AU1 produces y while AU2 concurrently forms x - (x>>3).
                ctrl_d.rer1       = 1'b1;
                ctrl_d.rar1       = 3'd1;
                ctrl_d.rer2       = 1'b1;
                ctrl_d.rar2       = 3'd1;
                ctrl_d.trictrl[1] = 1'b1;
                ctrl_d.au1        = 2'b01;
                ctrl_d.wer5       = 1'b1;
                ctrl_d.rr4        = 1'b1;
                ctrl_d.rer3       = 1'b1;
                ctrl_d.rar3       = 3'd0;
                ctrl_d.trictrl[7] = 1'b1;
                ctrl_d.au2        = 2'b00;
                ctrl_d.trictrl[9] = 1'b1;
                ctrl_d.wer3       = 1'b1;
                ctrl_d.war3       = 3'd1;
            end
            S_ADD: begin
                ctrl_d.rr5        = 1'b1;
                ctrl_d.trictrl[8] = 1'b1;
                ctrl_d.rer3       = 1'b1;
                ctrl_d.rar3       = 3'd1;
                ctrl_d.au2        = 2'b01;
                ctrl_d.trictrl[9] = 1'b1;
                ctrl_d.wer3       = 1'b1;
                ctrl_d.war3       = 3'd2;
            end
            S_MAX2: begin
                ctrl_d.rr4        = 1'b1;
                ctrl_d.trictrl[7] = 1'b1;
                ctrl_d.rer3       = 1'b1;
                ctrl_d.rar3       = 3'd2;
                ctrl_d.au2        = 2'b10;
                ctrl_d.trictrl[9] = 1'b1;
                ctrl_d.wer3       = 1'b1;
                ctrl_d.war3       = 3'd3;
            end
            S_OUT: begin
                ctrl_d.rer3 = 1'b1;
                ctrl_d.rar3 = 3'd3;
                ctrl_d.oe   = 1'b1;
                ctrl_d.done = 1'b1;
            end
            default: ctrl_d.busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign busy    = ctrl_q.busy;
    assign done    = ctrl_q.done;
    assign OE      = ctrl_q.oe;
    assign trictrl = ctrl_q.trictrl;
    assign AU1     = ctrl_q.au1;
    assign AU2     = ctrl_q.au2;
    assign WER1    = ctrl_q.wer1;
    assign RER1    = ctrl_q.rer1;
    assign WER2    = ctrl_q.wer2;
    assign RER2    = ctrl_q.rer2;
    assign WER3    = ctrl_q.wer3;
    assign RER3    = ctrl_q.rer3;
    assign WER4    = ctrl_q.wer4;
    assign RR4     = ctrl_q.rr4;
    assign WER5    = ctrl_q.wer5;
    assign RR5     = ctrl_q.rr5;
    assign WAR1    = ctrl_q.war1;
    assign RAR1    = ctrl_q.rar1;
    assign WAR2    = ctrl_q.war2;
    assign RAR2    = ctrl_q.rar2;
    assign WAR3    = ctrl_q.war3;
    assign RAR3    = ctrl_q.rar3;

endmodule

// File: tb/tb_sqrt_controller.sv
// Bench for sqrt_controller: a behavioural datapath is steered by the controller outputs and its
// result O is scored against a reference magnitude approximation.
module tb_sqrt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, OE;
    logic       WER1, RER1, WER2, RER2, WER3, RER3, WER4, RR4, WER5, RR5;
    logic [2:0] WAR1, RAR1, WAR2, RAR2, WAR3, RAR3;
    logic [1:0] AU1, AU2;
    logic [9:0] trictrl;

    logic [4:0] in1, in2;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    sqrt_controller dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .WER1(WER1), .RER1(RER1), .WER2(WER2), .RER2(RER2), .WER3(WER3), .RER3(RER3),
        .WAR1(WAR1), .RAR1(RAR1), .WAR2(WAR2), .RAR2(RAR2), .WAR3(WAR3), .RAR3(RAR3),
        .WER4(WER4), .RR4(RR4), .WER5(WER5), .RR5(RR5),
        .AU1(AU1), .AU2(AU2), .trictrl(trictrl), .OE(OE)
    );

    logic [44:0] ctrl_obs;
    assign ctrl_obs = {busy, done, OE, trictrl, AU2, AU1, WER4, RR4, WER5, RR5,
                       WER1, RER1, WER2, RER2, WER3, RER3, WAR1, RAR1, WAR2, RAR2, WAR3, RAR3};

    // Behavioural datapath driven by the controller
    logic [4:0] r1[8], r2[8], r3[8];
    logic [4:0] r4, r5;
    logic [4:0] rd1, rd2, rd3, au1_b, au1_out, au2_a, au2_out, wbus1, wbus2, wbus3, O;

    function automatic logic [4:0] abs5(input logic [4:0] v);
        return v[4] ? 5'(~v + 5'd1) : v;
    endfunction

    always_comb begin
        rd1     = RER1 ? r1[RAR1] : 5'bx;
        rd2     = RER2 ? r2[RAR2] : 5'bx;
        rd3     = RER3 ? r3[RAR3] : 5'bx;
        au1_b   = (trictrl[1] && !trictrl[0]) ? rd2 : 5'bx;
        au1_out = 5'bx;
        case (AU1)
            2'b00: au1_out = abs5(rd1);
            2'b01: au1_out = (rd1 < au1_b) ? rd1 : au1_b;
            2'b10: au1_out = (rd1 > au1_b) ? rd1 : au1_b;
            2'b11: au1_out = abs5(au1_b);
            default: au1_out = 5'bx;
        endcase
        au2_a = 5'bx;
        case ({trictrl[7], trictrl[8]})
            2'b10: au2_a = RR4 ? r4 : 5'bx;
            2'b01: au2_a = RR5 ? r5 : 5'bx;
            default: au2_a = 5'bx;
        endcase
        au2_out = 5'bx;
        case (AU2)
            2'b00: au2_out = au2_a - rd3;
            2'b01: au2_out = au2_a + rd3;
            2'b10: au2_out = (au2_a > rd3) ? au2_a : rd3;
            default: au2_out = 5'bx;
        endcase
        wbus1 = 5'bx;
        case ({trictrl[2], trictrl[3]})
            2'b10: wbus1 = in1;
            2'b01: wbus1 = au1_out;
            default: wbus1 = 5'bx;
        endcase
        wbus2 = 5'bx;
        case ({trictrl[4], trictrl[5]})
            2'b10: wbus2 = in2;
            2'b01: wbus2 = au1_out;
            default: wbus2 = 5'bx;
        endcase
        wbus3 = 5'bx;
        case ({trictrl[6], trictrl[9]})
            2'b10: wbus3 = au1_out >> 3;
            2'b01: wbus3 = au2_out;
            default: wbus3 = 5'bx;
        endcase
        O = OE ? rd3 : 5'bx;
    end

    always @(posedge clk) begin
        if (WER1) r1[WAR1] <= wbus1;
        if (WER2) r2[WAR2] <= wbus2;
        if (WER3) r3[WAR3] <= wbus3;
        if (WER4) r4 <= au1_out;
        if (WER5) r5 <= au1_out >> 1;
    end

    function automatic logic [4:0] ref_sqrt(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] aa, bb, x, y, t;
        aa = abs5(a);
        bb = abs5(b);
        x  = (aa > bb) ? aa : bb;
        y  = (aa > bb) ? bb : aa;
        t  = x - (x >> 3) + (y >> 1);
        return (t > x) ? t : x;
    endfunction

    // Expected control word for sequence position st (0 = IDLE, 1 = LOAD .. 8 = OUT)
    function automatic logic [44:0] exp_word(input int st);
        logic       b, d, oe;
        logic [9:0] tc;
        logic [1:0] a1, a2;
        logic       we1, re1, we2, re2, we3, re3, we4, r4e, we5, r5e;
        logic [2:0] wa1, ra1, wa2, ra2, wa3, ra3;
        {b, d, oe, tc, a1, a2} = '0;
        {we1, re1, we2, re2, we3, re3, we4, r4e, we5, r5e} = '0;
        {wa1, ra1, wa2, ra2, wa3, ra3} = '0;
        b = (st != 0);
        case (st)
            1: begin tc[2] = 1; tc[4] = 1; we1 = 1; we2 = 1; end
            2: begin re1 = 1; a1 = 2'b00; tc[3] = 1; we1 = 1; wa1 = 1; end
            3: begin re2 = 1; tc[1] = 1; a1 = 2'b11; tc[5] = 1; we2 = 1; wa2 = 1; end
            4: begin re1 = 1; ra1 = 1; re2 = 1; ra2 = 1; tc[1] = 1; a1 = 2'b10;
                     we4 = 1; tc[6] = 1; we3 = 1; wa3 = 0; end
            5: begin re1 = 1; ra1 = 1; re2 = 1; ra2 = 1; tc[1] = 1; a1 = 2'b01; we5 = 1;
                     r4e = 1; re3 = 1; ra3 = 0; tc[7] = 1; a2 = 2'b00; tc[9] = 1;
                     we3 = 1; wa3 = 1; end
            6: begin r5e = 1; tc[8] = 1; re3 = 1; ra3 = 1; a2 = 2'b01; tc[9] = 1;
                     we3 = 1; wa3 = 2; end
            7: begin r4e = 1; tc[7] = 1; re3 = 1; ra3 = 2; a2 = 2'b10; tc[9] = 1;
                     we3 = 1; wa3 = 3; end
            8: begin re3 = 1; ra3 = 3; oe = 1; d = 1; end
            default: b = 1'b0;
        endcase
        return {b, d, oe, tc, a2, a1, we4, r4e, we5, r5e,
                we1, re1, we2, re2, we3, re3, wa1, ra1, wa2, ra2, wa3, ra3};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs one operation; start is re-asserted at the positions flagged in extra_start.
    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [7:0] extra_start);
        in1   = a;
        in2   = b;
        start = 1'b1;
        sb.push_back(ref_sqrt(a, b));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ctrl_seq", {40'd0, 8'(i + 1), ctrl_obs} >> 0, {40'd0, 8'(i + 1), exp_word(i + 1)});
            start = extra_start[i];
        end
        tick();
        chk("idle_after_out", ctrl_obs, 45'd0);
        start = 1'b0;
    endtask

    // Per-cycle invariants plus scoreboard pop on done
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("tri_pairs", {trictrl[0] & trictrl[1], trictrl[2] & trictrl[3],
                              trictrl[4] & trictrl[5], trictrl[7] & trictrl[8],
                              trictrl[6] & trictrl[9]}, 5'd0);
            chk("done_without_oe", done & ~OE, 1'b0);
            if (done === 1'b1) begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) chk("result_O", O, sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc[$];
        rst   = 1'b1;
        start = 1'b1;
        in1   = 5'd0;
        in2   = 5'd0;
        repeat (2) begin
            tick();
            chk("reset_state", ctrl_obs, 45'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            tick();
            chk("idle_state", ctrl_obs, 45'd0);
        end

        run_op(5'd3, 5'd4, 8'b0000_0000);
        run_op(5'b11000, 5'd6, 8'b1000_0100);
        run_op(5'd0, 5'd0, 8'b0000_0000);

        // Abort in MINSUB: no result expected from this run
        in1   = 5'd7;
        in2   = 5'd1;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            chk("abort_seq", ctrl_obs, exp_word(i + 1));
        end
        rst = 1'b1;
        tick();
        chk("abort_reset", ctrl_obs, 45'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("abort_idle", ctrl_obs, 45'd0);
        end
        run_op(5'd15, 5'b10000, 8'b0000_0000);

        // Continuous start: three runs, spaced 9 cycles apart
        in1   = 5'd5;
        in2   = 5'b11101;
        start = 1'b1;
        repeat (3) sb.push_back(ref_sqrt(5'd5, 5'b11101));
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) dc.push_back(i);
            if (i == 20) start = 1'b0;
        end
        chk("cont_done_count", dc.size(), 3);
        for (int j = 0; j < dc.size(); j++) chk("cont_done_pos", dc[j], 7 + 9 * j);
        tick();
        chk("cont_idle", ctrl_obs, 45'd0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sqrt_controller.md
SQRT_CONTROLLER -- requirements
Module: sqrt_controller

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset, with no parameters.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  request one approximation of in1/in2, which are presented on the datapath inputs and held stable until done.
REQ-005 busy  out  1  high from the cycle after start is accepted until the OUT state completes.
REQ-006 done  out  1  one-cycle pulse; the result is valid on datapath O in the same cycle.
REQ-007 WER1, RER1, WER2, RER2, WER3, RER3  out  1 each  register-file write/read enables.
REQ-008 WAR1, RAR1, WAR2, RAR2, WAR3, RAR3  out  3 each  register-file write/read addresses.
REQ-009 WER4, RR4, WER5, RR5  out  1 each  write/read enables for the x-register (r4) and the y-half register (r5).
REQ-010 AU1, AU2  out  2 each  arithmetic-unit opcodes.
REQ-011 trictrl  out  10  bus-driver selects; OE  out  1  output enable.

Function
REQ-012 AU1 encoding SHALL be: 00 = |A|, 01 = MIN(A,B), 10 = MAX(A,B), 11 = |B|.
REQ-013 AU2 encoding SHALL be: 00 = A-B, 01 = A+B, 10 = MAX(A,B).
REQ-014 The algorithm SHALL be x=max(|a|,|b|), y=min(|a|,|b|), result = max(x - (x>>3) + (y>>1), x), with 5-bit unsigned wraparound.
REQ-015 The FSM SHALL have the states IDLE, LOAD, ABSA, ABSB, MAXX, MINSUB, ADD, MAX2 and OUT, encoded in a 4-bit state register.
REQ-016 IDLE: busy=0 and all control outputs are 0; start=1 moves to LOAD, otherwise the FSM stays in IDLE.
REQ-017 LOAD: trictrl[2]=1, trictrl[4]=1, WER1=1, WAR1=0, WER2=1 and WAR2=0, which loads a into r1[0] and b into r2[0].
REQ-018 ABSA: RER1=1, RAR1=0, AU1=00, trictrl[3]=1, WER1=1 and WAR1=1, which writes |a| to r1[1].
REQ-019 ABSB: RER2=1, RAR2=0, trictrl[1]=1, AU1=11, trictrl[5]=1, WER2=1 and WAR2=1, which writes |b| to r2[1].
REQ-020 MAXX: RER1=1, RAR1=1, RER2=1, RAR2=1, trictrl[1]=1, AU1=10, WER4=1, trictrl[6]=1, WER3=1 and WAR3=0, which stores x in r4 and x>>3 in r3[0].
REQ-021 MINSUB overlaps two operations in one cycle:
- AU1 path: the MAXX read controls with AU1=01 and WER5=1, which stores y>>1 in r5.
- AU2 path: RR4=1, RER3=1, RAR3=0, trictrl[7]=1, AU2=00, trictrl[9]=1, WER3=1 and WAR3=1, which stores x-(x>>3) in r3[1].
REQ-022 ADD: RR5=1, trictrl[8]=1, RER3=1, RAR3=1, AU2=01, trictrl[9]=1, WER3=1 and WAR3=2.
REQ-023 MAX2: RR4=1, trictrl[7]=1, RER3=1, RAR3=2, AU2=10, trictrl[9]=1, WER3=1 and WAR3=3.
REQ-024 OUT: RER3=1, RAR3=3, OE=1 and done=1, then the FSM moves unconditionally to IDLE.
REQ-025 Every non-IDLE state SHALL last exactly one cycle, and any control not listed for a state SHALL be 0.
REQ-026 If start is sampled high on cycle edge k, done SHALL be high during the eighth cycle after k, and busy SHALL be high for all 8 cycles LOAD..OUT.
REQ-027 start SHALL be ignored while busy=1; start high in the OUT cycle SHALL be ignored, and start high in the following IDLE cycle SHALL be accepted (back-to-back throughput of 1 result per 9 cycles).
REQ-028 The block SHALL never drive both bits of the pairs trictrl{0,1}, {2,3}, {4,5}, {7,8} or {6,9} in the same cycle.
REQ-029 All outputs SHALL be registered decodes of state, with no combinational path from start to any output.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, so that in the next cycle busy=0, done=0, OE=0, trictrl=0 and all enables, addresses and opcodes are 0.
REQ-031 A reset asserted in any state, including mid-operation, SHALL abort the computation, produce no done pulse, and give no guarantee of register-file contents.
REQ-032 rst SHALL dominate start in the same cycle.

Verification
REQ-033 rst for 2 cycles, then idle -> every output is 0 each cycle; busy=0.
REQ-034 in1=3, in2=4, start for 1 cycle -> the control words match REQ-017..024 in order; done occurs 8 cycles later with O=5.
REQ-035 in1=-8 (5'b11000), in2=6 -> O=10 at done; in1=0, in2=0 -> O=0.
REQ-036 start held high continuously -> done is pulsed every 9 cycles, and start pulses while busy produce no extra run.
REQ-037 rst asserted during MINSUB -> IDLE in the next cycle with all controls 0 and no done; a new start then yields a correct result.
REQ-038 A per-cycle assertion over all runs -> no mutually exclusive trictrl pair is ever both 1, and done is never asserted while OE=0.
